spmv_hbm_vec_responder: RTL and testbench
=========================================

SPMV_HBM_VEC_RESPONDER -- requirements
Module: spmv_hbm_vec_responder

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 1024, number of 256-bit words held; BASE_ADDR, default 48'h0, byte address of word 0.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 pcie_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 pcie_areset  in  1  asynchronous active-high reset.
REQ-005 s_axi_hbm_awaddr/awlen/awsize/awburst/awvalid  in  48/4/3/2/1  AXI3 write address; s_axi_hbm_awready  out  1.
REQ-006 s_axi_hbm_wdata/wstrb/wlast/wvalid  in  256/32/1/1  write data; s_axi_hbm_wready  out  1.
REQ-007 s_axi_hbm_bresp  out  2, s_axi_hbm_bvalid  out  1, s_axi_hbm_bready  in  1  write response.
REQ-008 s_axi_hbm_araddr/arlen/arsize/arburst/arvalid  in  48/4/3/2/1  read address; s_axi_hbm_arready  out  1.
REQ-009 s_axi_hbm_rdata/rresp/rlast/rvalid  out  256/2/1/1, s_axi_hbm_rready  in  1  read data.

Function
REQ-010 The block SHALL be the HBM-side AXI3 responder for the 256-bit master port of the PCIe-HBM path, backed by a dual-port DEPTH_WORDS x 256 array.
REQ-011 Word index SHALL be (addr - BASE_ADDR) >> 5; addr[4:0] ignored.
REQ-012 A burst SHALL be legal only if burst==INCR (2'b01), size==3'd5, and index+len < DEPTH_WORDS.
REQ-013 Illegal burst response SHALL be DECERR (2'b11) if out of range, else SLVERR (2'b10); range check takes priority.
REQ-014 Write FSM states SHALL be W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); AW accepted on awvalid&awready.
REQ-015 W_DATA SHALL accept exactly awlen+1 beats, one per wvalid&wready cycle, then go to W_RESP.
REQ-016 Legal bursts SHALL write bytes with wstrb[i]=1 only; illegal bursts SHALL accept and discard all beats.
REQ-017 wlast mismatch (asserted before final beat or absent on final beat) SHALL force bresp=SLVERR unless already DECERR; beat count, not wlast, ends the burst.
REQ-018 bvalid SHALL hold with stable bresp until bready; then W_IDLE, awready=1 next cycle.
REQ-019 Read FSM states SHALL be R_IDLE (arready=1), R_FETCH (array read issued, 1 cycle), R_DATA (rvalid=1).
REQ-020 In R_DATA rdata/rresp/rlast SHALL hold stable until rready; on handshake go to R_FETCH with index+1, or R_IDLE after beat arlen+1.
REQ-021 rlast SHALL be 1 only on beat arlen+1; illegal reads SHALL return rdata=0 with the REQ-013 code on every beat.
REQ-022 Read latency SHALL be 2 cycles from AR handshake to first rvalid; sustained rate 1 beat per 2 cycles with rready=1.
REQ-023 Read and write FSMs SHALL run independently; same-word read and write in one cycle SHALL return old data (read-first).
REQ-024 Only one outstanding burst per direction; awready/arready SHALL be 0 outside their idle states.
REQ-025 Beat counters SHALL be 4-bit; index SHALL never wrap because wrapping bursts are rejected by REQ-012.

Reset
REQ-026 While pcie_areset=1: both FSMs idle, awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=0, rdata=0.
REQ-027 First edge after release SHALL set awready=arready=1; array contents are not reset.
REQ-028 Reset mid-burst SHALL abandon the burst with no response; words already written stay written.

Verification
REQ-029 Write awaddr=0x40, awlen=3, size 5, INCR, wstrb all 1, data 0xA0..0xA3 -> bresp=OKAY; read same -> 4 beats 0xA0..0xA3, rlast on beat 4, rresp=OKAY.
REQ-030 Write word 5 with wstrb=32'h0000_000F data 0xFFFF_FFFF over prior 0 -> readback 0x0000_0000_..._FFFF_FFFF (low 4 bytes only).
REQ-031 awaddr=(DEPTH_WORDS-2)*32, awlen=3 -> 4 beats accepted, bresp=DECERR, words DEPTH_WORDS-2/-1 unchanged; matching read -> 4 beats rdata=0 rresp=DECERR.
REQ-032 arburst=FIXED, arlen=1 -> 2 beats rresp=SLVERR rdata=0; awlen=2 with wlast on beat 2 -> bresp=SLVERR after beat 3.
REQ-033 rready toggled 1/0 every cycle on 4-beat read, bready held 0 for 5 cycles -> rdata/rlast and bvalid/bresp stable while stalled, no beat lost.
REQ-034 pcie_areset pulsed during beat 2 of a 4-beat write -> all outputs 0 in reset, no bvalid after release, beat 1 word updated, new write accepted next cycle.

Source files
------------

// File: rtl/spmv_hbm_vec_responder.sv
// ---------------------------------------------------------------------------
// spmv_hbm_vec_responder
//
// HBM-side AXI3 slave for the 256-bit master port of the PCIe-HBM path. It
// stores DEPTH_WORDS words of 256 bits in a dual-port array. Independent write
// and read state machines each allow one outstanding burst. Only INCR bursts
// of 32-byte beats that stay inside the array are legal. Illegal bursts are
// fully handshaken but have no effect on the array:
//   - out of range            -> DECERR
//   - wrong burst type / size -> SLVERR
//
// Ports
//   pcie_aclk, pcie_areset          clock, asynchronous active-high reset
//   s_axi_hbm_aw*                   write address channel (awready out)
//   s_axi_hbm_w*                    write data channel    (wready out)
//   s_axi_hbm_b*                    write response        (bresp/bvalid out)
//   s_axi_hbm_ar*                   read address channel  (arready out)
//   s_axi_hbm_r*                    read data channel     (rdata/rresp/rlast/rvalid out)
// ---------------------------------------------------------------------------
module spmv_hbm_vec_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [47:0] BASE_ADDR   = 48'h0
) (
  input  logic         pcie_aclk,
  input  logic         pcie_areset,
  input  logic [47:0]  s_axi_hbm_awaddr,
  input  logic [3:0]   s_axi_hbm_awlen,
  input  logic [2:0]   s_axi_hbm_awsize,
  input  logic [1:0]   s_axi_hbm_awburst,
  input  logic         s_axi_hbm_awvalid,
  output logic         s_axi_hbm_awready,
  input  logic [255:0] s_axi_hbm_wdata,
  input  logic [31:0]  s_axi_hbm_wstrb,
  input  logic         s_axi_hbm_wlast,
  input  logic         s_axi_hbm_wvalid,
  output logic         s_axi_hbm_wready,
  output logic [1:0]   s_axi_hbm_bresp,
  output logic         s_axi_hbm_bvalid,
  input  logic         s_axi_hbm_bready,
  input  logic [47:0]  s_axi_hbm_araddr,
  input  logic [3:0]   s_axi_hbm_arlen,
  input  logic [2:0]   s_axi_hbm_arsize,
  input  logic [1:0]   s_axi_hbm_arburst,
  input  logic         s_axi_hbm_arvalid,
  output logic         s_axi_hbm_arready,
  output logic [255:0] s_axi_hbm_rdata,
  output logic [1:0]   s_axi_hbm_rresp,
  output logic         s_axi_hbm_rlast,
  output logic         s_axi_hbm_rvalid,
  input  logic         s_axi_hbm_rready
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_e;

  // Range is checked on the full-width word index so that addresses far
  // outside the array, or below BASE_ADDR, cannot alias into it.
  function automatic logic [1:0] burstResp(input logic [47:0] word,
                                           input logic [3:0]  len,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
    logic [48:0] lastWord;
    lastWord = {1'b0, word} + {45'd0, len};
    if (lastWord >= 49'(DEPTH_WORDS))
      burstResp = RESP_DECERR;
    else if (burst != 2'b01 || size != 3'd5)
      burstResp = RESP_SLVERR;
    else
      burstResp = RESP_OKAY;
  endfunction

  logic [255:0] mem_q [DEPTH_WORDS];

  // Ready outputs stay low until the first edge after reset is released.
  logic alive_q;

  logic [47:0] awWord, arWord;
  logic [1:0]  awCode, arCode;

  assign awWord = (s_axi_hbm_awaddr - BASE_ADDR) >> 5;
  assign arWord = (s_axi_hbm_araddr - BASE_ADDR) >> 5;
  assign awCode = burstResp(awWord, s_axi_hbm_awlen, s_axi_hbm_awsize, s_axi_hbm_awburst);
  assign arCode = burstResp(arWord, s_axi_hbm_arlen, s_axi_hbm_arsize, s_axi_hbm_arburst);

  wState_e      wState_q, wState_d;
  logic [IW-1:0] wIdx_q, wIdx_d;
  logic [3:0]   wBeat_q, wBeat_d;
  logic [3:0]   wLen_q, wLen_d;
  logic [1:0]   wResp_q, wResp_d;
  logic         wLegal_q, wLegal_d;
  logic         memWe;

  rState_e      rState_q, rState_d;
  logic [IW-1:0] rIdx_q, rIdx_d;
  logic [3:0]   rBeat_q, rBeat_d;
  logic [3:0]   rLen_q, rLen_d;
  logic [1:0]   rCode_q, rCode_d;
  logic [255:0] rData_q, rData_d;
  logic         rLast_q, rLast_d;

  always_ff @(posedge pcie_aclk or posedge pcie_areset) begin
    if (pcie_areset) alive_q <= 1'b0;
    else             alive_q <= 1'b1;
  end

  always_ff @(posedge pcie_aclk or posedge pcie_areset) begin
    if (pcie_areset) begin
      wState_q <= W_IDLE;
      wIdx_q   <= '0;
      wBeat_q  <= '0;
      wLen_q   <= '0;
      wResp_q  <= RESP_OKAY;
      wLegal_q <= 1'b0;
    end else begin
      wState_q <= wState_d;
      wIdx_q   <= wIdx_d;
      wBeat_q  <= wBeat_d;
      wLen_q   <= wLen_d;
      wResp_q  <= wResp_d;
      wLegal_q <= wLegal_d;
    end
  end

  // The beat count, not wlast, ends a write burst; a misplaced or missing
  // wlast only downgrades the response (DECERR is never overridden).
  always_comb begin
    wState_d          = wState_q;
    wIdx_d            = wIdx_q;
    wBeat_d           = wBeat_q;
    wLen_d            = wLen_q;
    wResp_d           = wResp_q;
    wLegal_d          = wLegal_q;
    memWe             = 1'b0;
    s_axi_hbm_awready = 1'b0;
    s_axi_hbm_wready  = 1'b0;
    s_axi_hbm_bvalid  = 1'b0;
    case (wState_q)
      W_IDLE: begin
        s_axi_hbm_awready = alive_q;
        if (alive_q && s_axi_hbm_awvalid) begin
          wIdx_d   = awWord[IW-1:0];
          wLen_d   = s_axi_hbm_awlen;
          wBeat_d  = 4'd0;
          wResp_d  = awCode;
          wLegal_d = (awCode == RESP_OKAY);
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_hbm_wready = 1'b1;
        if (s_axi_hbm_wvalid) begin
          memWe = wLegal_q;
          if ((s_axi_hbm_wlast != (wBeat_q == wLen_q)) && (wResp_q != RESP_DECERR))
            wResp_d = RESP_SLVERR;
          if (wBeat_q == wLen_q) begin
            wState_d = W_RESP;
          end else begin
            wBeat_d = wBeat_q + 4'd1;
            wIdx_d  = wIdx_q + IW'(1);
          end
        end
      end
      W_RESP: begin
        s_axi_hbm_bvalid = 1'b1;
        if (s_axi_hbm_bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  assign s_axi_hbm_bresp = s_axi_hbm_bvalid ? wResp_q : 2'b00;

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge pcie_aclk) begin
    if (memWe) begin
      for (int b = 0; b < 32; b++) begin
        if (s_axi_hbm_wstrb[b]) mem_q[wIdx_q][b*8 +: 8] <= s_axi_hbm_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge pcie_aclk or posedge pcie_areset) begin
    if (pcie_areset) begin
      rState_q <= R_IDLE;
      rIdx_q   <= '0;
      rBeat_q  <= '0;
      rLen_q   <= '0;
      rCode_q  <= RESP_OKAY;
      rData_q  <= '0;
      rLast_q  <= 1'b0;
    end else begin
      rState_q <= rState_d;
      rIdx_q   <= rIdx_d;
      rBeat_q  <= rBeat_d;
      rLen_q   <= rLen_d;
      rCode_q  <= rCode_d;
      rData_q  <= rData_d;
      rLast_q  <= rLast_d;
    end
  end

  // The array is sampled in R_FETCH using the pre-edge contents, so a write to
  // the same word on the same edge is not visible (read-first). Every beat
  // therefore costs one fetch cycle plus one data cycle.
  always_comb begin
    rState_d          = rState_q;
    rIdx_d            = rIdx_q;
    rBeat_d           = rBeat_q;
    rLen_d            = rLen_q;
    rCode_d           = rCode_q;
    rData_d           = rData_q;
    rLast_d           = rLast_q;
    s_axi_hbm_arready = 1'b0;
    s_axi_hbm_rvalid  = 1'b0;
    case (rState_q)
      R_IDLE: begin
        s_axi_hbm_arready = alive_q;
        if (alive_q && s_axi_hbm_arvalid) begin
          rIdx_d   = arWord[IW-1:0];
          rLen_d   = s_axi_hbm_arlen;
          rBeat_d  = 4'd0;
          rCode_d  = arCode;
          rState_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rData_d  = (rCode_q == RESP_OKAY) ? mem_q[rIdx_q] : '0;
        rLast_d  = (rBeat_q == rLen_q);
        rState_d = R_DATA;
      end
      R_DATA: begin
        s_axi_hbm_rvalid = 1'b1;
        if (s_axi_hbm_rready) begin
          if (rBeat_q == rLen_q) begin
            rLast_d  = 1'b0;
            rState_d = R_IDLE;
          end else begin
            rBeat_d  = rBeat_q + 4'd1;
            rIdx_d   = rIdx_q + IW'(1);
            rState_d = R_FETCH;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  assign s_axi_hbm_rdata = rData_q;
  assign s_axi_hbm_rresp = rCode_q;
  assign s_axi_hbm_rlast = rLast_q;

endmodule

// File: tb/tb_spmv_hbm_vec_responder.sv
// ---------------------------------------------------------------------------
// tb_spmv_hbm_vec_responder
//
// Bench for spmv_hbm_vec_responder using a 64-word array. A word-level model
// of the array and the burst legality rules predicts bresp, rdata, rresp and
// rlast. The bench starts with directed bursts: strobes, the range boundary,
// FIXED bursts, wlast errors, back-pressure, and reset in the middle of a
// burst. It then runs randomised write/read pairs.
// ---------------------------------------------------------------------------
module tb_spmv_hbm_vec_responder;

  localparam int          DEPTH = 64;
  localparam logic [47:0] BASE  = 48'h0;

  logic         pcie_aclk = 1'b0;
  logic         pcie_areset;
  logic [47:0]  s_axi_hbm_awaddr;
  logic [3:0]   s_axi_hbm_awlen;
  logic [2:0]   s_axi_hbm_awsize;
  logic [1:0]   s_axi_hbm_awburst;
  logic         s_axi_hbm_awvalid;
  logic         s_axi_hbm_awready;
  logic [255:0] s_axi_hbm_wdata;
  logic [31:0]  s_axi_hbm_wstrb;
  logic         s_axi_hbm_wlast;
  logic         s_axi_hbm_wvalid;
  logic         s_axi_hbm_wready;
  logic [1:0]   s_axi_hbm_bresp;
  logic         s_axi_hbm_bvalid;
  logic         s_axi_hbm_bready;
  logic [47:0]  s_axi_hbm_araddr;
  logic [3:0]   s_axi_hbm_arlen;
  logic [2:0]   s_axi_hbm_arsize;
  logic [1:0]   s_axi_hbm_arburst;
  logic         s_axi_hbm_arvalid;
  logic         s_axi_hbm_arready;
  logic [255:0] s_axi_hbm_rdata;
  logic [1:0]   s_axi_hbm_rresp;
  logic         s_axi_hbm_rlast;
  logic         s_axi_hbm_rvalid;
  logic         s_axi_hbm_rready;

  always #5 pcie_aclk = ~pcie_aclk;

  spmv_hbm_vec_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .pcie_aclk         (pcie_aclk),
    .pcie_areset       (pcie_areset),
    .s_axi_hbm_awaddr  (s_axi_hbm_awaddr),
    .s_axi_hbm_awlen   (s_axi_hbm_awlen),
    .s_axi_hbm_awsize  (s_axi_hbm_awsize),
    .s_axi_hbm_awburst (s_axi_hbm_awburst),
    .s_axi_hbm_awvalid (s_axi_hbm_awvalid),
    .s_axi_hbm_awready (s_axi_hbm_awready),
    .s_axi_hbm_wdata   (s_axi_hbm_wdata),
    .s_axi_hbm_wstrb   (s_axi_hbm_wstrb),
    .s_axi_hbm_wlast   (s_axi_hbm_wlast),
    .s_axi_hbm_wvalid  (s_axi_hbm_wvalid),
    .s_axi_hbm_wready  (s_axi_hbm_wready),
    .s_axi_hbm_bresp   (s_axi_hbm_bresp),
    .s_axi_hbm_bvalid  (s_axi_hbm_bvalid),
    .s_axi_hbm_bready  (s_axi_hbm_bready),
    .s_axi_hbm_araddr  (s_axi_hbm_araddr),
    .s_axi_hbm_arlen   (s_axi_hbm_arlen),
    .s_axi_hbm_arsize  (s_axi_hbm_arsize),
    .s_axi_hbm_arburst (s_axi_hbm_arburst),
    .s_axi_hbm_arvalid (s_axi_hbm_arvalid),
    .s_axi_hbm_arready (s_axi_hbm_arready),
    .s_axi_hbm_rdata   (s_axi_hbm_rdata),
    .s_axi_hbm_rresp   (s_axi_hbm_rresp),
    .s_axi_hbm_rlast   (s_axi_hbm_rlast),
    .s_axi_hbm_rvalid  (s_axi_hbm_rvalid),
    .s_axi_hbm_rready  (s_axi_hbm_rready)
  );

  logic [255:0] model [DEPTH];
  logic [255:0] wBuf [16];
  logic [31:0]  wStrbBuf [16];
  int checks = 0;
  int errors = 0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pcie_aclk);
    #1;
  endtask

  // Response code derived directly from the burst legality rules.
  function automatic logic [1:0] expectedResp(input logic [47:0] addr, input int len, input int size, input int burst);
    longint word;
    word = longint'(addr - BASE) / 32;
    if (word + len > DEPTH - 1) return 2'b11;
    if (burst != 1 || size != 5) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_awready"}, s_axi_hbm_awready, 0);
    checkOutput({name, "_arready"}, s_axi_hbm_arready, 0);
    checkOutput({name, "_wready"},  s_axi_hbm_wready, 0);
    checkOutput({name, "_bvalid"},  s_axi_hbm_bvalid, 0);
    checkOutput({name, "_rvalid"},  s_axi_hbm_rvalid, 0);
    checkOutput({name, "_rlast"},   s_axi_hbm_rlast, 0);
    checkOutput({name, "_bresp"},   s_axi_hbm_bresp, 0);
    checkOutput({name, "_rresp"},   s_axi_hbm_rresp, 0);
    checkOutput({name, "_rdata"},   s_axi_hbm_rdata, 0);
  endtask

  // One write burst from wBuf/wStrbBuf. wlastAt is the beat carrying wlast
  // (len is correct, len+1 means never). bStall holds bready low that many
  // cycles while bvalid is up.
  task automatic writeBurst(input string name, input logic [47:0] addr, input int len, input int size,
                            input int burst, input int wlastAt, input int bStall);
    logic [1:0] exp;
    logic [1:0] code;
    int word;
    int guard;
    code = expectedResp(addr, len, size, burst);
    exp  = code;
    if (wlastAt != len && exp != 2'b11) exp = 2'b10;
    word = int'((addr - BASE) >> 5);
    s_axi_hbm_awaddr  = addr;
    s_axi_hbm_awlen   = 4'(len);
    s_axi_hbm_awsize  = 3'(size);
    s_axi_hbm_awburst = 2'(burst);
    s_axi_hbm_awvalid = 1'b1;
    guard = 0;
    while (!s_axi_hbm_awready && guard < 20) begin tick(); guard++; end
    checkOutput({name, "_aw_wait"}, guard < 20, 1);
    tick();
    s_axi_hbm_awvalid = 1'b0;
    checkOutput({name, "_awready_busy"}, s_axi_hbm_awready, 0);
    for (int b = 0; b <= len; b++) begin
      s_axi_hbm_wdata  = wBuf[b];
      s_axi_hbm_wstrb  = wStrbBuf[b];
      s_axi_hbm_wlast  = (b == wlastAt);
      s_axi_hbm_wvalid = 1'b1;
      guard = 0;
      while (!s_axi_hbm_wready && guard < 20) begin tick(); guard++; end
      checkOutput({name, "_w_wait"}, guard < 20, 1);
      tick();
    end
    s_axi_hbm_wvalid = 1'b0;
    s_axi_hbm_wlast  = 1'b0;
    if (code == 2'b00) begin
      for (int b = 0; b <= len; b++)
        for (int i = 0; i < 32; i++)
          if (wStrbBuf[b][i]) model[word + b][i*8 +: 8] = wBuf[b][i*8 +: 8];
    end
    for (int s = 0; s < bStall; s++) begin
      checkOutput({name, "_bvalid_stall"}, s_axi_hbm_bvalid, 1);
      checkOutput({name, "_bresp_stall"}, s_axi_hbm_bresp, exp);
      tick();
    end
    s_axi_hbm_bready = 1'b1;
    checkOutput({name, "_bvalid"}, s_axi_hbm_bvalid, 1);
    checkOutput({name, "_bresp"}, s_axi_hbm_bresp, exp);
    tick();
    s_axi_hbm_bready = 1'b0;
    checkOutput({name, "_bvalid_done"}, s_axi_hbm_bvalid, 0);
    checkOutput({name, "_awready_after"}, s_axi_hbm_awready, 1);
  endtask

  // One read burst compared beat by beat with the model. With toggle set,
  // rready is low for one cycle before each accepted beat.
  task automatic readBurst(input string name, input logic [47:0] addr, input int len, input int size,
                           input int burst, input bit toggle);
    logic [1:0] exp;
    logic [255:0] expData;
    logic [255:0] heldData;
    int word;
    int guard;
    exp  = expectedResp(addr, len, size, burst);
    word = int'((addr - BASE) >> 5);
    s_axi_hbm_araddr  = addr;
    s_axi_hbm_arlen   = 4'(len);
    s_axi_hbm_arsize  = 3'(size);
    s_axi_hbm_arburst = 2'(burst);
    s_axi_hbm_arvalid = 1'b1;
    guard = 0;
    while (!s_axi_hbm_arready && guard < 20) begin tick(); guard++; end
    checkOutput({name, "_ar_wait"}, guard < 20, 1);
    tick();
    s_axi_hbm_arvalid = 1'b0;
    checkOutput({name, "_lat_fetch"}, s_axi_hbm_rvalid, 0);
    checkOutput({name, "_arready_busy"}, s_axi_hbm_arready, 0);
    tick();
    checkOutput({name, "_lat_data"}, s_axi_hbm_rvalid, 1);
    for (int b = 0; b <= len; b++) begin
      guard = 0;
      while (!s_axi_hbm_rvalid && guard < 20) begin tick(); guard++; end
      checkOutput($sformatf("%s_r_wait_b%0d", name, b), guard < 20, 1);
      expData = '0;
      if (exp == 2'b00) expData = model[word + b];
      checkOutput($sformatf("%s_rdata_b%0d", name, b), s_axi_hbm_rdata, expData);
      checkOutput($sformatf("%s_rresp_b%0d", name, b), s_axi_hbm_rresp, exp);
      checkOutput($sformatf("%s_rlast_b%0d", name, b), s_axi_hbm_rlast, (b == len));
      if (toggle) begin
        heldData = s_axi_hbm_rdata;
        s_axi_hbm_rready = 1'b0;
        tick();
        checkOutput($sformatf("%s_rvalid_hold_b%0d", name, b), s_axi_hbm_rvalid, 1);
        checkOutput($sformatf("%s_rdata_hold_b%0d", name, b), s_axi_hbm_rdata, heldData);
        checkOutput($sformatf("%s_rlast_hold_b%0d", name, b), s_axi_hbm_rlast, (b == len));
      end
      s_axi_hbm_rready = 1'b1;
      tick();
      s_axi_hbm_rready = 1'b0;
    end
    checkOutput({name, "_rvalid_done"}, s_axi_hbm_rvalid, 0);
    checkOutput({name, "_arready_after"}, s_axi_hbm_arready, 1);
  endtask

  // One randomised write followed by a randomised read. Both may be illegal.
  task automatic applyStimulus(input int iter);
    int len, size, burst, wlastAt;
    logic [47:0] addr;
    len   = int'($urandom_range(0, 15));
    addr  = 48'($urandom_range(0, DEPTH + 4)) * 48'd32 + 48'($urandom_range(0, 31));
    size  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 5;
    burst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 1;
    wlastAt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len + 1)) : len;
    for (int b = 0; b < 16; b++) begin
      wBuf[b]     = rand256();
      wStrbBuf[b] = $urandom();
    end
    writeBurst($sformatf("rnd%0d_wr", iter), addr, len, size, burst, wlastAt, int'($urandom_range(0, 3)));
    len   = int'($urandom_range(0, 15));
    addr  = 48'($urandom_range(0, DEPTH + 4)) * 48'd32 + 48'($urandom_range(0, 31));
    size  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 5;
    burst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 1;
    readBurst($sformatf("rnd%0d_rd", iter), addr, len, size, burst, $urandom_range(0, 1) == 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pcie_areset       = 1'b1;
    s_axi_hbm_awaddr  = '0;
    s_axi_hbm_awlen   = '0;
    s_axi_hbm_awsize  = '0;
    s_axi_hbm_awburst = '0;
    s_axi_hbm_awvalid = 1'b0;
    s_axi_hbm_wdata   = '0;
    s_axi_hbm_wstrb   = '0;
    s_axi_hbm_wlast   = 1'b0;
    s_axi_hbm_wvalid  = 1'b0;
    s_axi_hbm_bready  = 1'b0;
    s_axi_hbm_araddr  = '0;
    s_axi_hbm_arlen   = '0;
    s_axi_hbm_arsize  = '0;
    s_axi_hbm_arburst = '0;
    s_axi_hbm_arvalid = 1'b0;
    s_axi_hbm_rready  = 1'b0;

    // Reset values and the first edge after release.
    tick();
    tick();
    checkResetOutputs("rst");
    pcie_areset = 1'b0;
    checkOutput("rst_release_awready", s_axi_hbm_awready, 0);
    tick();
    checkOutput("first_edge_awready", s_axi_hbm_awready, 1);
    checkOutput("first_edge_arready", s_axi_hbm_arready, 1);

    // Clear the whole array so the model starts from known contents.
    for (int b = 0; b < 16; b++) begin
      wBuf[b]     = '0;
      wStrbBuf[b] = 32'hFFFF_FFFF;
    end
    for (int blk = 0; blk < DEPTH / 16; blk++)
      writeBurst($sformatf("clr%0d", blk), 48'(blk * 16 * 32), 15, 5, 1, 15, 0);

    // Byte strobes: only the low four bytes of word 5 change.
    wBuf[0]     = '1;
    wStrbBuf[0] = 32'h0000_000F;
    writeBurst("strb_wr", 48'd160, 0, 5, 1, 0, 0);
    readBurst("strb_rd", 48'd160, 0, 5, 1, 1'b0);

    // Basic 4-beat write and readback at 0x40.
    for (int b = 0; b < 4; b++) begin
      wBuf[b]     = 256'hA0 + 256'(b);
      wStrbBuf[b] = 32'hFFFF_FFFF;
    end
    writeBurst("basic_wr", 48'h40, 3, 5, 1, 3, 0);
    readBurst("basic_rd", 48'h40, 3, 5, 1, 1'b0);

    // Out-of-range burst at the top of the array; the last two words stay put.
    for (int b = 0; b < 4; b++) wBuf[b] = rand256();
    writeBurst("oor_wr", 48'((DEPTH - 2) * 32), 3, 5, 1, 3, 0);
    readBurst("oor_rd", 48'((DEPTH - 2) * 32), 3, 5, 1, 1'b0);
    readBurst("oor_keep", 48'((DEPTH - 2) * 32), 1, 5, 1, 1'b0);

    // Exactly reaching the last word is legal.
    writeBurst("edge_wr", 48'((DEPTH - 4) * 32), 3, 5, 1, 3, 0);
    readBurst("edge_rd", 48'((DEPTH - 4) * 32), 3, 5, 1, 1'b0);

    // FIXED read, bad size write, early wlast, missing wlast.
    readBurst("fixed_rd", 48'h0, 1, 5, 0, 1'b0);
    writeBurst("size_wr", 48'h200, 1, 4, 1, 1, 0);
    for (int b = 0; b < 3; b++) wBuf[b] = rand256();
    writeBurst("early_wlast", 48'h300, 2, 5, 1, 1, 0);
    writeBurst("no_wlast", 48'h380, 2, 5, 1, 3, 0);
    readBurst("wlast_rd", 48'h300, 7, 5, 1, 1'b0);

    // Back-pressure on both channels.
    for (int b = 0; b < 4; b++) wBuf[b] = rand256();
    writeBurst("stall_wr", 48'h400, 3, 5, 1, 3, 5);
    readBurst("stall_rd", 48'h400, 3, 5, 1, 1'b1);

    // Reset during beat 2 of a 4-beat write to words 10..13.
    for (int b = 0; b < 4; b++) wBuf[b] = rand256();
    s_axi_hbm_awaddr  = 48'd320;
    s_axi_hbm_awlen   = 4'd3;
    s_axi_hbm_awsize  = 3'd5;
    s_axi_hbm_awburst = 2'd1;
    s_axi_hbm_awvalid = 1'b1;
    checkOutput("mid_rst_awready", s_axi_hbm_awready, 1);
    tick();
    s_axi_hbm_awvalid = 1'b0;
    s_axi_hbm_wdata   = wBuf[0];
    s_axi_hbm_wstrb   = 32'hFFFF_FFFF;
    s_axi_hbm_wvalid  = 1'b1;
    checkOutput("mid_rst_wready", s_axi_hbm_wready, 1);
    tick();
    model[10] = wBuf[0];
    s_axi_hbm_wdata = wBuf[1];
    pcie_areset = 1'b1;
    #1;
    checkResetOutputs("mid_rst");
    tick();
    checkResetOutputs("mid_rst_hold");
    s_axi_hbm_wvalid = 1'b0;
    pcie_areset = 1'b0;
    tick();
    checkOutput("mid_rst_post_awready", s_axi_hbm_awready, 1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("mid_rst_no_bvalid", s_axi_hbm_bvalid, 0);
      tick();
    end
    for (int b = 0; b < 16; b++) begin
      wBuf[b]     = rand256();
      wStrbBuf[b] = 32'hFFFF_FFFF;
    end
    writeBurst("post_rst_wr", 48'd640, 1, 5, 1, 1, 0);
    readBurst("post_rst_rd", 48'd320, 3, 5, 1, 1'b0);

    // Randomised traffic.
    for (int it = 0; it < 30; it++) applyStimulus(it);

    // Final sweep of the whole array against the model.
    for (int blk = 0; blk < DEPTH / 16; blk++)
      readBurst($sformatf("sweep%0d", blk), 48'(blk * 16 * 32), 15, 5, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
